// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//   Fetch-control stage between the program counter and decode. It holds the
//   IF/ID instruction register and resolves JMP/BRZ/HALT from that registered
//   instruction. It drives branch_en/target back to the PC. It sequences program
//   start/done with the test bench and owns the branch-target LUT.
//
// Ports
//   clk         in   clock, all state on rising edge
//   reset_n     in   asynchronous active-low reset
//   start       in   request to (re)start the program at pc 0
//   done        out  program reached HALT (registered)
//   pc          in   current program counter (visibility only)
//   inst        in   instruction memory read data at pc
//   alu_zero    in   ALU zero flag, used by BRZ
//   fetch_hold  out  forces the PC to 0 on the next edge
//   branch_en   out  PC loads target on the next edge
//   target      out  branch destination = lut[operand index]
//   inst_valid  out  inst_out is a live instruction for decode
//   inst_out    out  IF/ID register contents
//   lut_we      in   LUT write enable (honoured in IDLE/LOAD/HALT only)
//   lut_waddr   in   LUT write index
//   lut_wdata   in   LUT write data
// -----------------------------------------------------------------------------
module fetch_ctrl #(
    parameter int PC_WIDTH   = 11,
    parameter int INST_WIDTH = 9,
    parameter int LUT_AW     = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    output logic                  done,
    input  logic [PC_WIDTH-1:0]   pc,
    input  logic [INST_WIDTH-1:0] inst,
    input  logic                  alu_zero,
    output logic                  fetch_hold,
    output logic                  branch_en,
    output logic [PC_WIDTH-1:0]   target,
    output logic                  inst_valid,
    output logic [INST_WIDTH-1:0] inst_out,
    input  logic                  lut_we,
    input  logic [LUT_AW-1:0]     lut_waddr,
    input  logic [PC_WIDTH-1:0]   lut_wdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_FLUSH,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_JMP  = 4'hD;
    localparam logic [3:0] OP_BRZ  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;
    localparam logic [4:0] HALT_OPERAND = 5'h1F;

    state_t state, state_nxt;

    logic [PC_WIDTH-1:0] lut [2**LUT_AW];

    logic [3:0] opcode;
    logic [4:0] operand;
    logic       run_valid;
    logic       taken;
    logic       halt_seen;
    logic       hold_state;
    logic       unused_bits;

    assign opcode  = inst_out[INST_WIDTH-1 -: 4];
    assign operand = inst_out[4:0];

    // pc is observed only; operand bits above the LUT index are don't-care.
    assign unused_bits = ^{pc, operand};

    always_comb begin
        run_valid  = (state == S_RUN) && inst_valid;
        taken      = run_valid && ((opcode == OP_JMP) ||
                                   ((opcode == OP_BRZ) && alu_zero));
        halt_seen  = run_valid && (opcode == OP_HALT) && (operand == HALT_OPERAND);
        hold_state = (state == S_IDLE) || (state == S_LOAD) || (state == S_HALT);
    end

    assign fetch_hold = start | hold_state;
    assign branch_en  = taken;
    // Target is looked up unconditionally so the PC sees a stable value.
    assign target     = lut[operand[LUT_AW-1:0]];

    // Next-state logic; start has priority from every state.
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = S_LOAD;
        end else begin
            case (state)
                S_IDLE:  state_nxt = S_IDLE;
                S_LOAD:  state_nxt = S_RUN;
                S_RUN: begin
                    if (taken)          state_nxt = S_FLUSH;
                    else if (halt_seen) state_nxt = S_HALT;
                    else                state_nxt = S_RUN;
                end
                S_FLUSH: state_nxt = S_RUN;
                S_HALT:  state_nxt = S_HALT;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // IF/ID register and done flag. A taken branch squashes the wrong-path
    // pc+1 instruction being captured on the same edge; the FLUSH cycle then
    // captures the instruction at the target. Decode never sees anything
    // fetched after a HALT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inst_out   <= '0;
            inst_valid <= 1'b0;
            done       <= 1'b0;
        end else if (start) begin
            inst_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    inst_out   <= inst;
                    inst_valid <= !(taken || halt_seen);
                    if (halt_seen) done <= 1'b1;
                end
                S_FLUSH: begin
                    inst_out   <= inst;
                    inst_valid <= 1'b1;
                end
                default: inst_valid <= 1'b0;
            endcase
        end
    end

    // Branch-target LUT: writable only while the program is not running.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2**LUT_AW; i++) lut[i] <= '0;
        end else if (lut_we && hold_state) begin
            lut[lut_waddr] <= lut_wdata;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

    localparam int PCW = 11;
    localparam int IW  = 9;
    localparam int AW  = 4;

    logic           clk = 1'b0;
    logic           reset_n = 1'b1;
    logic           start = 1'b0;
    logic           done;
    logic [PCW-1:0] pc;
    logic [IW-1:0]  inst;
    logic           alu_zero = 1'b0;
    logic           fetch_hold;
    logic           branch_en;
    logic [PCW-1:0] target;
    logic           inst_valid;
    logic [IW-1:0]  inst_out;
    logic           lut_we = 1'b0;
    logic [AW-1:0]  lut_waddr = '0;
    logic [PCW-1:0] lut_wdata = '0;

    logic [IW-1:0]  mem [0:2047];
    logic [PCW-1:0] lut_m [0:15];

    int total  = 0;
    int passed = 0;

    fetch_ctrl #(.PC_WIDTH(PCW), .INST_WIDTH(IW), .LUT_AW(AW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .done(done), .pc(pc),
        .inst(inst), .alu_zero(alu_zero), .fetch_hold(fetch_hold),
        .branch_en(branch_en), .target(target), .inst_valid(inst_valid),
        .inst_out(inst_out), .lut_we(lut_we), .lut_waddr(lut_waddr),
        .lut_wdata(lut_wdata)
    );

    always #5 clk = ~clk;

    // Program counter and instruction memory surrounding the block.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)        pc <= '0;
        else if (fetch_hold) pc <= '0;
        else if (branch_en)  pc <= target;
        else                 pc <= pc + 1'b1;
    end
    assign inst = mem[pc];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
        $fatal(1);
    end

    task automatic clear_mem();
        for (int i = 0; i < 2048; i++) mem[i] = '0;
    endtask

    task automatic reset_dut();
        start = 0; lut_we = 0; alu_zero = 0;
        reset_n = 1;
        #1 reset_n = 0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1;
    endtask

    task automatic lut_write(input logic [AW-1:0] a, input logic [PCW-1:0] d);
        lut_we = 1; lut_waddr = a; lut_wdata = d;
        @(negedge clk);
        lut_we = 0;
    endtask

    // Returns on the negedge after the LOAD edge; two more negedges later
    // inst_out holds mem[0] with inst_valid=1.
    task automatic start_prog();
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic test_reset();
        reset_n = 1;
        #1 reset_n = 0;
        @(negedge clk);
        total++; if ({inst_valid, done, branch_en, fetch_hold} !== 4'b0001) $display("FAIL reset_flags got %b need 0001", {inst_valid, done, branch_en, fetch_hold}); else passed++;
        total++; if (inst_out !== 9'h000 || target !== 11'h000) $display("FAIL reset_data got inst_out=%h target=%h need 000/000", inst_out, target); else passed++;
        reset_n = 1;
        clear_mem();
        lut_write(0, 11'h123);
        total++; if (target !== 11'h123) $display("FAIL idle_lut_write got %h need 123", target); else passed++;
        start_prog();
        repeat (2) @(negedge clk);
        total++; if (inst_valid !== 1'b1) $display("FAIL run_before_reset got valid=%b need 1", inst_valid); else passed++;
        #2 reset_n = 0;
        #1;
        total++; if ({inst_valid, done, branch_en, fetch_hold} !== 4'b0001) $display("FAIL midrun_reset_flags got %b need 0001", {inst_valid, done, branch_en, fetch_hold}); else passed++;
        total++; if (target !== 11'h000) $display("FAIL midrun_reset_lut got %h need 000", target); else passed++;
        @(negedge clk);
        reset_n = 1;
    endtask

    task automatic test_brz_taken();
        reset_dut(); clear_mem();
        mem[1] = 9'h1C3; mem[2] = 9'h0B7; mem[11'h040] = 9'h0A5;
        lut_write(3, 11'h040);
        alu_zero = 1;
        start_prog();
        repeat (2) @(negedge clk);
        total++; if ({inst_valid, branch_en} !== 2'b10 || inst_out !== 9'h000) $display("FAIL brz_pc0 got v/b=%b inst=%h need 10/000", {inst_valid, branch_en}, inst_out); else passed++;
        @(negedge clk);
        total++; if ({inst_valid, branch_en} !== 2'b11 || target !== 11'h040) $display("FAIL brz_taken got v/b=%b target=%h need 11/040", {inst_valid, branch_en}, target); else passed++;
        @(negedge clk);
        total++; if ({inst_valid, branch_en} !== 2'b00) $display("FAIL brz_bubble got v/b=%b need 00", {inst_valid, branch_en}); else passed++;
        @(negedge clk);
        total++; if (inst_valid !== 1'b1 || inst_out !== 9'h0A5) $display("FAIL brz_target_inst got v=%b inst=%h need 1/0a5", inst_valid, inst_out); else passed++;
    endtask

    task automatic test_brz_untaken();
        reset_dut(); clear_mem();
        mem[1] = 9'h1C3; mem[2] = 9'h0B7; mem[3] = 9'h066;
        lut_write(3, 11'h040);
        alu_zero = 0;
        start_prog();
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++; if ({inst_valid, branch_en} !== 2'b10 || inst_out !== mem[k]) $display("FAIL brz_untaken_%0d got v/b=%b inst=%h need 10/%h", k, {inst_valid, branch_en}, inst_out, mem[k]); else passed++;
        end
    endtask

    task automatic test_halt_restart();
        reset_dut(); clear_mem();
        mem[0] = 9'h011; mem[5] = 9'h1FF;
        start_prog();
        repeat (7) @(negedge clk);
        total++; if (inst_valid !== 1'b1 || inst_out !== 9'h1FF || done !== 1'b0) $display("FAIL halt_in_ifid got v=%b inst=%h done=%b need 1/1ff/0", inst_valid, inst_out, done); else passed++;
        @(negedge clk);
        total++; if ({done, fetch_hold, inst_valid} !== 3'b110) $display("FAIL halt_done got %b need 110", {done, fetch_hold, inst_valid}); else passed++;
        @(negedge clk);
        total++; if (pc !== 11'h000 || done !== 1'b1) $display("FAIL halt_pc got pc=%h done=%b need 000/1", pc, done); else passed++;
        start = 1;
        @(negedge clk);
        start = 0;
        total++; if (done !== 1'b0) $display("FAIL restart_done got %b need 0", done); else passed++;
        repeat (2) @(negedge clk);
        total++; if (inst_valid !== 1'b1 || inst_out !== 9'h011) $display("FAIL rerun_pc0 got v=%b inst=%h need 1/011", inst_valid, inst_out); else passed++;
    endtask

    task automatic test_lut_write_guard();
        reset_dut(); clear_mem();
        mem[1] = 9'h002; mem[2] = 9'h1FF;
        start_prog();
        repeat (2) @(negedge clk);
        lut_we = 1; lut_waddr = 2; lut_wdata = 11'h7FF;
        @(negedge clk);
        lut_we = 0;
        total++; if (inst_out !== 9'h002 || target !== 11'h000) $display("FAIL lut_run_write got inst=%h target=%h need 002/000", inst_out, target); else passed++;
        repeat (2) @(negedge clk);
        total++; if (done !== 1'b1) $display("FAIL lut_halt_reached got done=%b need 1", done); else passed++;
        lut_write(2, 11'h7FF);
        start_prog();
        repeat (3) @(negedge clk);
        total++; if (inst_out !== 9'h002 || target !== 11'h7FF) $display("FAIL lut_halt_write got inst=%h target=%h need 002/7ff", inst_out, target); else passed++;
    endtask

    task automatic test_back_to_back();
        reset_dut(); clear_mem();
        mem[0] = 9'h1A3; mem[11'h010] = 9'h1A4; mem[11'h020] = 9'h055;
        lut_write(3, 11'h010);
        lut_write(4, 11'h020);
        start_prog();
        repeat (2) @(negedge clk);
        total++; if ({inst_valid, branch_en} !== 2'b11 || target !== 11'h010) $display("FAIL b2b_jmp1 got v/b=%b target=%h need 11/010", {inst_valid, branch_en}, target); else passed++;
        @(negedge clk);
        total++; if ({inst_valid, branch_en} !== 2'b00) $display("FAIL b2b_bubble1 got %b need 00", {inst_valid, branch_en}); else passed++;
        @(negedge clk);
        total++; if ({inst_valid, branch_en} !== 2'b11 || target !== 11'h020 || inst_out !== 9'h1A4) $display("FAIL b2b_jmp2 got v/b=%b target=%h inst=%h need 11/020/1a4", {inst_valid, branch_en}, target, inst_out); else passed++;
        @(negedge clk);
        total++; if ({inst_valid, branch_en} !== 2'b00) $display("FAIL b2b_bubble2 got %b need 00", {inst_valid, branch_en}); else passed++;
        @(negedge clk);
        total++; if (inst_valid !== 1'b1 || inst_out !== 9'h055) $display("FAIL b2b_land got v=%b inst=%h need 1/055", inst_valid, inst_out); else passed++;
        start = 1;
        #1;
        total++; if (fetch_hold !== 1'b1) $display("FAIL midrun_start_hold got %b need 1", fetch_hold); else passed++;
        @(negedge clk);
        start = 0;
        total++; if (inst_valid !== 1'b0) $display("FAIL midrun_start_squash got %b need 0", inst_valid); else passed++;
    endtask

    // Random programs checked against an instruction-set level model: the
    // stream decode sees must equal architectural execution order, with one
    // bubble after each taken branch and none otherwise.
    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            logic [PCW-1:0] apc;
            logic [IW-1:0]  ins;
            logic           zflag, tk, hl, bubble, seen, halted;
            reset_dut();
            for (int i = 0; i < 2048; i++)
                mem[i] = ($urandom_range(0, 99) < 4) ? 9'h1FF : IW'($urandom_range(0, 511));
            for (int j = 0; j < 16; j++) begin
                lut_m[j] = PCW'($urandom_range(0, 2047));
                lut_write(AW'(j), lut_m[j]);
            end
            zflag = 1'($urandom_range(0, 1));
            alu_zero = zflag;
            apc = '0; bubble = 0; seen = 0; halted = 0;
            start_prog();
            for (int c = 0; c < 400 && !halted; c++) begin
                @(negedge clk);
                if (seen || inst_valid) begin
                    seen = 1;
                    ins = mem[apc];
                    tk  = (ins[8:5] == 4'hD) || ((ins[8:5] == 4'hE) && zflag);
                    hl  = (ins == 9'h1FF);
                    total++; if (inst_valid !== !bubble || done !== 1'b0) $display("FAIL rnd%0d_valid c=%0d got v=%b done=%b need %b/0", it, c, inst_valid, done, !bubble); else passed++;
                    if (inst_valid) begin
                        total++; if (inst_out !== ins || branch_en !== tk) $display("FAIL rnd%0d_inst c=%0d got inst=%h be=%b need %h/%b", it, c, inst_out, branch_en, ins, tk); else passed++;
                        if (tk) begin
                            total++; if (target !== lut_m[ins[3:0]]) $display("FAIL rnd%0d_target c=%0d got %h need %h", it, c, target, lut_m[ins[3:0]]); else passed++;
                        end
                        bubble = tk;
                        apc = tk ? lut_m[ins[3:0]] : apc + 1'b1;
                        halted = hl;
                    end else begin
                        total++; if (branch_en !== 1'b0) $display("FAIL rnd%0d_bubble_be c=%0d got %b need 0", it, c, branch_en); else passed++;
                        bubble = 0;
                    end
                end
            end
            if (!seen) begin
                total++;
                $display("FAIL rnd%0d_timeout got no valid instruction, need one", it);
            end
            if (halted) begin
                @(negedge clk);
                total++; if ({done, inst_valid, fetch_hold} !== 3'b101) $display("FAIL rnd%0d_halt got %b need 101", it, {done, inst_valid, fetch_hold}); else passed++;
            end
        end
    endtask

    initial begin
        clear_mem();
        test_reset();
        test_brz_taken();
        test_brz_untaken();
        test_halt_restart();
        test_lut_write_guard();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
